// File: rtl/dot_product_tm_pkg.sv
// Shared constants and width helpers for the time-multiplexed dot-product engine.
package dot_product_pkg;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

    // Sum of NDATA full-width products never needs more than clog2(NDATA) guard bits.
    function automatic int acc_width(input int nbits, input int ndata);
        return 2 * nbits + clog2(ndata);
    endfunction

endpackage

// File: rtl/dot_product_tm_if.sv
// Operand / result handshake bundle between a producer and the dot-product engine.
interface dot_product_tm_if
    import dot_product_pkg::*;
#(
    parameter int NBITS = 4,
    parameter int NDATA = 8
);
    localparam int ACCW = acc_width(NBITS, NDATA);

    logic                     in_valid;
    logic                     in_ready;
    logic                     is_signed;
    logic [NDATA*NBITS-1:0]   a;
    logic [NDATA*NBITS-1:0]   b;
    logic                     out_valid;
    logic                     out_ready;
    logic [NDATA*2*NBITS-1:0] prod_out;
    logic [ACCW-1:0]          dot_out;

    modport master (
        output in_valid, is_signed, a, b, out_ready,
        input  in_ready, out_valid, prod_out, dot_out
    );

    modport slave (
        input  in_valid, is_signed, a, b, out_ready,
        output in_ready, out_valid, prod_out, dot_out
    );

endinterface

// File: rtl/dot_product_tm_lane_mult.sv
// L parallel NBITS x NBITS multipliers with a shared signed/unsigned mode and their widened sum.
module lane_mult
    import dot_product_pkg::*;
#(
    parameter int NBITS = 4,
    parameter int L     = 4,
    parameter int ACCW  = 11
) (
    input  logic                   is_signed,
    input  logic [L*NBITS-1:0]     a,
    input  logic [L*NBITS-1:0]     b,
    output logic [L*2*NBITS-1:0]   prod,
    output logic [ACCW-1:0]        sum
);

    logic [L-1:0][2*NBITS-1:0] p;

    for (genvar i = 0; i < L; i++) begin : g_lane
        logic signed [NBITS:0] ae, be;
        // One extra bit carries the sign in signed mode and a zero in unsigned mode.
        assign ae   = {is_signed & a[i*NBITS+NBITS-1], a[i*NBITS +: NBITS]};
        assign be   = {is_signed & b[i*NBITS+NBITS-1], b[i*NBITS +: NBITS]};
        assign p[i] = (2*NBITS)'(ae) * (2*NBITS)'(be);
    end

    assign prod = p;

    always_comb begin
        sum = '0;
        for (int i = 0; i < L; i++)
            sum = sum + {{(ACCW-2*NBITS){is_signed & p[i][2*NBITS-1]}}, p[i]};
    end

endmodule

// File: rtl/dot_product_tm.sv
// Time-multiplexed scalar-product engine: NDATA/NMUL lanes per pass over NMUL passes,
// returning the product vector and the accumulated sum behind a valid/ready handshake.
module dot_product_tm
    import dot_product_pkg::*;
#(
    parameter int NBITS = 4,
    parameter int NDATA = 8,
    parameter int NMUL  = 2
) (
    input  logic             clk,
    input  logic             reset,
    dot_product_tm_if.slave  bus
);

    localparam int L    = NDATA / NMUL;
    localparam int ACCW = acc_width(NBITS, NDATA);
    localparam int OW   = NDATA * NBITS;
    localparam int PW   = NDATA * 2 * NBITS;
    localparam int CW   = (NMUL > 1) ? clog2(NMUL) : 1;

    if (NDATA % NMUL != 0) begin : g_bad_nmul
        $error("NDATA must be a multiple of NMUL");
    end

    logic [1:0]       state_q;
    logic             in_ready_q;
    logic [CW-1:0]    cnt_q;
    logic             sgn_q;
    logic [OW-1:0]    a_q, b_q;
    logic [PW-1:0]    prod_q;
    logic [ACCW-1:0]  acc_q;

    logic [L*2*NBITS-1:0] lane_prod;
    logic [ACCW-1:0]      lane_sum;

    lane_mult #(.NBITS(NBITS), .L(L), .ACCW(ACCW)) u_lane_mult (
        .is_signed (sgn_q),
        .a         (a_q[L*NBITS-1:0]),
        .b         (b_q[L*NBITS-1:0]),
        .prod      (lane_prod),
        .sum       (lane_sum)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            in_ready_q <= 1'b0;
            cnt_q      <= '0;
            sgn_q      <= 1'b0;
            a_q        <= '0;
            b_q        <= '0;
            prod_q     <= '0;
            acc_q      <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    in_ready_q <= 1'b1;
                    if (bus.in_valid && in_ready_q) begin
                        a_q        <= bus.a;
                        b_q        <= bus.b;
                        sgn_q      <= bus.is_signed;
                        acc_q      <= '0;
                        cnt_q      <= '0;
                        in_ready_q <= 1'b0;
                        state_q    <= S_RUN;
                    end
                end
                S_RUN: begin
                    // New lane products enter at the top so element i ends in slot i.
                    prod_q <= (prod_q >> (L*2*NBITS)) | (PW'(lane_prod) << ((NDATA-L)*2*NBITS));
                    acc_q  <= acc_q + lane_sum;
                    a_q    <= a_q >> (L*NBITS);
                    b_q    <= b_q >> (L*NBITS);
                    cnt_q  <= cnt_q + 1'b1;
                    if (cnt_q == CW'(NMUL-1)) state_q <= S_DONE;
                end
                S_DONE: begin
                    if (bus.out_ready) begin
                        state_q    <= S_IDLE;
                        in_ready_q <= 1'b1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = (state_q == S_DONE);
    assign bus.prod_out  = prod_q;
    assign bus.dot_out   = acc_q;

endmodule
